// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
//
// Machine-mode CSR storage for a single-hart RV32I core. It consumes the CSR
// ALU result and supplies the current CSR value back to it, keeps the trap
// state (mstatus/mepc/mcause/mtvec) and runs the 64-bit cycle/instret
// counters.
//
// Ports
//   clk          system clock, every state update on the rising edge
//   rst          synchronous active-high reset
//   csr_raddr    read address
//   csr_rdata    combinational read data for csr_raddr (0 when unsupported)
//   csr_illegal  raddr unsupported, or a write to an unsupported/RO address
//   csr_we       write strobe
//   csr_waddr    write address
//   csr_wdata    write data from the CSR ALU
//   retire       one instruction retired this cycle
//   trap_valid   take a trap this cycle (mepc/mcause/mstatus update)
//   trap_cause   mcause value for the trap
//   trap_pc      PC saved to mepc
//   mret_valid   MRET executes this cycle
//   meip         external interrupt line (level)
//   mtip         timer interrupt line (level)
//   mtvec_out    current mtvec
//   mepc_out     current mepc
//   irq_pending  an enabled interrupt is pending and globally enabled
// ---------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_valid,
    input  logic        meip,
    input  logic        mtip,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    // State. mtvec and mepc keep only bits [31:2]; the low bits always read 0.
    logic        mstatus_mie_reg,  mstatus_mie_next;
    logic        mstatus_mpie_reg, mstatus_mpie_next;
    logic        mie_mtie_reg;
    logic        mie_meie_reg;
    logic [29:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [29:0] mepc_reg,   mepc_next;
    logic [31:0] mcause_reg, mcause_next;

    // Counter values, exported from the generate loop below (0 = mcycle, 1 = minstret).
    logic [63:0] mcycle_val;
    logic [63:0] minstret_val;

    logic        w_legal;
    logic        wr_ok;
    logic        r_legal;
    logic [31:0] rdata_c;

    // -----------------------------------------------------------------------
    // Write address decode. misa and mip accept (and drop) writes; the
    // user-level counter shadows do not.
    // -----------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b0;
        case (csr_waddr)
            ADDR_MSTATUS, ADDR_MISA, ADDR_MIE, ADDR_MTVEC,
            ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP,
            ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    assign wr_ok = csr_we & w_legal;

    // -----------------------------------------------------------------------
    // Read port: purely combinational, returns the pre-edge state.
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_c = 32'h0;
        r_legal = 1'b1;
        case (csr_raddr)
            ADDR_MSTATUS:   rdata_c = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
            ADDR_MISA:      rdata_c = MISA_VALUE;
            ADDR_MIE:       rdata_c = {20'b0, mie_meie_reg, 3'b0, mie_mtie_reg, 7'b0};
            ADDR_MTVEC:     rdata_c = {mtvec_reg, 2'b00};
            ADDR_MSCRATCH:  rdata_c = mscratch_reg;
            ADDR_MEPC:      rdata_c = {mepc_reg, 2'b00};
            ADDR_MCAUSE:    rdata_c = mcause_reg;
            ADDR_MIP:       rdata_c = {20'b0, meip, 3'b0, mtip, 7'b0};
            ADDR_MCYCLE,   ADDR_CYCLE:    rdata_c = mcycle_val[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   rdata_c = mcycle_val[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  rdata_c = minstret_val[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: rdata_c = minstret_val[63:32];
            default: begin
                rdata_c = 32'h0;
                r_legal = 1'b0;
            end
        endcase
    end

    assign csr_rdata   = rdata_c;
    assign csr_illegal = ~r_legal | (csr_we & ~w_legal);

    // -----------------------------------------------------------------------
    // Trap state next-value logic. A trap owns mstatus/mepc/mcause for the
    // cycle; MRET owns only mstatus, so a CSR write to mepc/mcause alongside
    // MRET still lands.
    // -----------------------------------------------------------------------
    always_comb begin
        mstatus_mie_next  = mstatus_mie_reg;
        mstatus_mpie_next = mstatus_mpie_reg;
        mepc_next         = mepc_reg;
        mcause_next       = mcause_reg;
        if (trap_valid) begin
            mepc_next         = trap_pc[31:2];
            mcause_next       = trap_cause;
            mstatus_mpie_next = mstatus_mie_reg;
            mstatus_mie_next  = 1'b0;
        end else begin
            if (mret_valid) begin
                mstatus_mie_next  = mstatus_mpie_reg;
                mstatus_mpie_next = 1'b1;
            end else if (wr_ok && csr_waddr == ADDR_MSTATUS) begin
                mstatus_mie_next  = csr_wdata[3];
                mstatus_mpie_next = csr_wdata[7];
            end
            if (wr_ok && csr_waddr == ADDR_MEPC) begin
                mepc_next = csr_wdata[31:2];
            end
            if (wr_ok && csr_waddr == ADDR_MCAUSE) begin
                mcause_next = csr_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_mtie_reg     <= 1'b0;
            mie_meie_reg     <= 1'b0;
            mtvec_reg        <= RESET_MTVEC[31:2];
            mscratch_reg     <= 32'h0;
            mepc_reg         <= 30'h0;
            mcause_reg       <= 32'h0;
        end else begin
            mstatus_mie_reg  <= mstatus_mie_next;
            mstatus_mpie_reg <= mstatus_mpie_next;
            mepc_reg         <= mepc_next;
            mcause_reg       <= mcause_next;
            if (wr_ok && csr_waddr == ADDR_MIE) begin
                mie_mtie_reg <= csr_wdata[7];
                mie_meie_reg <= csr_wdata[11];
            end
            if (wr_ok && csr_waddr == ADDR_MTVEC) begin
                mtvec_reg <= csr_wdata[31:2];
            end
            if (wr_ok && csr_waddr == ADDR_MSCRATCH) begin
                mscratch_reg <= csr_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // 64-bit counters. A write to either half freezes the counter for that
    // cycle: the written half takes wdata, the other half holds.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            localparam logic [11:0] LO_ADDR = (gi == 0) ? ADDR_MCYCLE  : ADDR_MINSTRET;
            localparam logic [11:0] HI_ADDR = (gi == 0) ? ADDR_MCYCLEH : ADDR_MINSTRETH;

            logic [63:0] cnt_reg, cnt_next;
            logic        inc;
            logic        wr_lo;
            logic        wr_hi;

            assign inc   = (gi == 0) ? 1'b1 : retire;
            assign wr_lo = wr_ok && (csr_waddr == LO_ADDR);
            assign wr_hi = wr_ok && (csr_waddr == HI_ADDR);

            always_comb begin
                cnt_next = cnt_reg;
                if (wr_lo) begin
                    cnt_next[31:0] = csr_wdata;
                end else if (wr_hi) begin
                    cnt_next[63:32] = csr_wdata;
                end else if (inc) begin
                    cnt_next = cnt_reg + 64'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 64'h0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign mcycle_val   = gen_cnt[0].cnt_reg;
    assign minstret_val = gen_cnt[1].cnt_reg;

    // -----------------------------------------------------------------------
    // Outputs to the core's trap logic
    // -----------------------------------------------------------------------
    assign mtvec_out   = {mtvec_reg, 2'b00};
    assign mepc_out    = {mepc_reg, 2'b00};
    assign irq_pending = mstatus_mie_reg & ((mie_meie_reg & meip) | (mie_mtie_reg & mtip));

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
//
// Self-checking bench for csr_file. Each scenario task drives stimulus one
// clock at a time, pushes the expected CSR read values into a scoreboard
// queue and then pops them, presenting each address on the read port and
// comparing. Direct outputs (mtvec_out, mepc_out, irq_pending, csr_illegal)
// are compared inline. Inputs change 1 ns after the rising edge; reads are
// sampled in the following few ns, well before the next edge.
// ---------------------------------------------------------------------------
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        meip;
    logic        mtip;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp;
    } rd_t;

    rd_t sb[$];

    csr_file dut (
        .clk         (clk),
        .rst         (rst),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .csr_we      (csr_we),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .retire      (retire),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .mret_valid  (mret_valid),
        .meip        (meip),
        .mtip        (mtip),
        .mtvec_out   (mtvec_out),
        .mepc_out    (mepc_out),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] addr, input logic [31:0] exp);
        rd_t item;
        item.addr = addr;
        item.exp  = exp;
        sb.push_back(item);
    endtask

    task automatic wr_start(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        csr_raddr = addr;
    endtask

    task automatic test_reset();
        rd_t item;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        csr_raddr = 12'h300;
        #1;
        checks++;
        if (mtvec_out !== 32'h0) begin errors++; $display("FAIL reset_mtvec_out got %h exp %h", mtvec_out, 32'h0); end
        checks++;
        if (mepc_out !== 32'h0) begin errors++; $display("FAIL reset_mepc_out got %h exp %h", mepc_out, 32'h0); end
        checks++;
        if (irq_pending !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_pending); end
        checks++;
        if (csr_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", csr_illegal); end
        push(12'h300, 32'h0000_1800);
        push(12'h305, 32'h0);
        push(12'hB00, 32'h0);
        push(12'h341, 32'h0);
        push(12'h304, 32'h0);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("reset read %h = %h", item.addr, csr_rdata);
        end
        repeat (10) tick();
        push(12'hB00, 32'd10);
        push(12'hB80, 32'd0);
        push(12'hC00, 32'd10);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("idle read %h = %h", item.addr, csr_rdata);
        end
    endtask

    task automatic test_write_illegal();
        rd_t item;
        wr_start(12'h305, 32'h8000_0103);
        #1;
        checks++;
        if (csr_illegal !== 1'b0) begin errors++; $display("FAIL mtvec_wr_illegal got %b exp 0", csr_illegal); end
        tick();
        csr_we = 1'b0;
        checks++;
        if (mtvec_out !== 32'h8000_0100) begin errors++; $display("FAIL mtvec_out got %h exp %h", mtvec_out, 32'h8000_0100); end
        push(12'h305, 32'h8000_0100);
        wr_start(12'h301, 32'h0);
        #1;
        checks++;
        if (csr_illegal !== 1'b0) begin errors++; $display("FAIL misa_wr_illegal got %b exp 0", csr_illegal); end
        tick();
        csr_we = 1'b0;
        push(12'h301, 32'h4000_0100);
        wr_start(12'h341, 32'h0000_0103);
        tick();
        csr_we = 1'b0;
        push(12'h341, 32'h0000_0100);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("write read %h = %h", item.addr, csr_rdata);
        end
        // Seed mcycle, then try writing its read-only shadow.
        wr_start(12'hB00, 32'h0000_1000);
        tick();
        wr_start(12'hC00, 32'h0);
        #1;
        checks++;
        if (csr_illegal !== 1'b1) begin errors++; $display("FAIL cycle_wr_illegal got %b exp 1", csr_illegal); end
        tick();
        csr_we = 1'b0;
        push(12'hB00, 32'h0000_1001);
        push(12'hC00, 32'h0000_1001);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("illegal-write read %h = %h", item.addr, csr_rdata);
        end
        csr_raddr = 12'h7C0;
        #1;
        checks++;
        if (csr_illegal !== 1'b1) begin errors++; $display("FAIL rd_7c0_illegal got %b exp 1", csr_illegal); end
        checks++;
        if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rd_7c0_data got %h exp 0", csr_rdata); end
        $display("read 7c0 illegal=%b data=%h", csr_illegal, csr_rdata);
    endtask

    task automatic test_irq_trap();
        rd_t item;
        wr_start(12'h300, 32'hFFFF_FFFF);
        tick();
        wr_start(12'h304, 32'hFFFF_FFFF);
        tick();
        csr_we = 1'b0;
        push(12'h300, 32'h0000_1888);
        push(12'h304, 32'h0000_0880);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("mask read %h = %h", item.addr, csr_rdata);
        end
        wr_start(12'h304, 32'h0000_0800);
        tick();
        csr_we = 1'b0;
        mtip = 1'b1;
        #1;
        checks++;
        if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_mtip_masked got %b exp 0", irq_pending); end
        meip = 1'b1;
        #1;
        checks++;
        if (irq_pending !== 1'b1) begin errors++; $display("FAIL irq_meip got %b exp 1", irq_pending); end
        push(12'h304, 32'h0000_0800);
        push(12'h344, 32'h0000_0880);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("irq read %h = %h", item.addr, csr_rdata);
        end
        mtip = 1'b0;
        trap_valid = 1'b1;
        trap_cause = 32'h8000_000B;
        trap_pc    = 32'h0000_0102;
        tick();
        trap_valid = 1'b0;
        checks++;
        if (mepc_out !== 32'h0000_0100) begin errors++; $display("FAIL trap_mepc_out got %h exp %h", mepc_out, 32'h100); end
        checks++;
        if (irq_pending !== 1'b0) begin errors++; $display("FAIL trap_irq got %b exp 0", irq_pending); end
        push(12'h342, 32'h8000_000B);
        push(12'h341, 32'h0000_0100);
        push(12'h300, 32'h0000_1880);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("trap read %h = %h", item.addr, csr_rdata);
        end
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        checks++;
        if (irq_pending !== 1'b1) begin errors++; $display("FAIL mret_irq got %b exp 1", irq_pending); end
        push(12'h300, 32'h0000_1888);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("mret read %h = %h", item.addr, csr_rdata);
        end
        meip = 1'b0;
    endtask

    task automatic test_priority();
        rd_t item;
        // Trap and MRET together: trap wins (MRET alone would give 0x1888).
        trap_valid = 1'b1;
        mret_valid = 1'b1;
        trap_cause = 32'h0000_0002;
        trap_pc    = 32'h0000_0200;
        tick();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        push(12'h300, 32'h0000_1880);
        push(12'h341, 32'h0000_0200);
        push(12'h342, 32'h0000_0002);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("trap+mret read %h = %h", item.addr, csr_rdata);
        end
        // Trap with an unrelated write: mscratch still commits.
        trap_valid = 1'b1;
        trap_cause = 32'h0000_0003;
        trap_pc    = 32'h0000_0304;
        wr_start(12'h340, 32'hDEAD_BEEF);
        tick();
        trap_valid = 1'b0;
        csr_we     = 1'b0;
        push(12'h340, 32'hDEAD_BEEF);
        push(12'h341, 32'h0000_0304);
        push(12'h342, 32'h0000_0003);
        push(12'h300, 32'h0000_1800);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("trap+we read %h = %h", item.addr, csr_rdata);
        end
        // Trap with a write to mepc: the write is dropped.
        trap_valid = 1'b1;
        trap_cause = 32'h0000_0004;
        trap_pc    = 32'h0000_0400;
        wr_start(12'h341, 32'h1234_5678);
        tick();
        trap_valid = 1'b0;
        csr_we     = 1'b0;
        push(12'h341, 32'h0000_0400);
        push(12'h342, 32'h0000_0004);
        // MRET with a write to mstatus: MRET wins (the write would give 0x1800).
        mret_valid = 1'b1;
        wr_start(12'h300, 32'h0000_0000);
        tick();
        mret_valid = 1'b0;
        csr_we     = 1'b0;
        push(12'h300, 32'h0000_1880);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("priority read %h = %h", item.addr, csr_rdata);
        end
    endtask

    task automatic test_counters();
        rd_t item;
        wr_start(12'hB80, 32'h0000_0005);
        tick();
        wr_start(12'hB00, 32'hFFFF_FFFF);
        tick();
        csr_we = 1'b0;
        push(12'hB00, 32'hFFFF_FFFF);
        push(12'hB80, 32'h0000_0005);
        push(12'hC80, 32'h0000_0005);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("cnt seed read %h = %h", item.addr, csr_rdata);
        end
        tick();
        push(12'hB00, 32'h0000_0000);
        push(12'hB80, 32'h0000_0006);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("cnt carry read %h = %h", item.addr, csr_rdata);
        end
        wr_start(12'hB00, 32'h0000_0055);
        tick();
        csr_we = 1'b0;
        push(12'hB00, 32'h0000_0055);
        push(12'hB80, 32'h0000_0006);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("cnt wr-lo read %h = %h", item.addr, csr_rdata);
        end
        // Writing the high half holds the low half (no increment this cycle).
        wr_start(12'hB80, 32'h0000_0007);
        tick();
        csr_we = 1'b0;
        push(12'hB00, 32'h0000_0055);
        push(12'hB80, 32'h0000_0007);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("cnt wr-hi read %h = %h", item.addr, csr_rdata);
        end
    endtask

    task automatic test_instret();
        rd_t item;
        retire = 1'b1;
        tick();
        tick();
        wr_start(12'hB02, 32'h0);
        tick();
        csr_we = 1'b0;
        tick();
        tick();
        retire = 1'b0;
        push(12'hB02, 32'd2);
        push(12'hC02, 32'd2);
        push(12'hB82, 32'd0);
        push(12'hC82, 32'd0);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("instret read %h = %h", item.addr, csr_rdata);
        end
        wr_start(12'hC02, 32'h0000_0099);
        #1;
        checks++;
        if (csr_illegal !== 1'b1) begin errors++; $display("FAIL instret_wr_illegal got %b exp 1", csr_illegal); end
        tick();
        csr_we = 1'b0;
        push(12'hC02, 32'd2);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("instret ro read %h = %h", item.addr, csr_rdata);
        end
    endtask

    task automatic test_mid_reset();
        rd_t item;
        rst        = 1'b1;
        trap_valid = 1'b1;
        trap_cause = 32'h0000_0005;
        trap_pc    = 32'h0000_0500;
        retire     = 1'b1;
        wr_start(12'h340, 32'h0000_0001);
        tick();
        rst        = 1'b0;
        trap_valid = 1'b0;
        retire     = 1'b0;
        csr_we     = 1'b0;
        checks++;
        if (mtvec_out !== 32'h0) begin errors++; $display("FAIL midrst_mtvec_out got %h exp 0", mtvec_out); end
        checks++;
        if (mepc_out !== 32'h0) begin errors++; $display("FAIL midrst_mepc_out got %h exp 0", mepc_out); end
        push(12'hB00, 32'h0);
        push(12'hB80, 32'h0);
        push(12'hB02, 32'h0);
        push(12'h340, 32'h0);
        push(12'h300, 32'h0000_1800);
        push(12'h342, 32'h0);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            csr_raddr = item.addr;
            #1;
            checks++;
            if (csr_rdata !== item.exp) begin errors++; $display("FAIL rd_%h got %h exp %h", item.addr, csr_rdata, item.exp); end
            else $display("mid-reset read %h = %h", item.addr, csr_rdata);
        end
    endtask

    initial begin
        rst        = 1'b1;
        csr_raddr  = 12'h0;
        csr_we     = 1'b0;
        csr_waddr  = 12'h0;
        csr_wdata  = 32'h0;
        retire     = 1'b0;
        trap_valid = 1'b0;
        trap_cause = 32'h0;
        trap_pc    = 32'h0;
        mret_valid = 1'b0;
        meip       = 1'b0;
        mtip       = 1'b0;
        test_reset();
        test_write_illegal();
        test_irq_trap();
        test_priority();
        test_counters();
        test_instret();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
